// File: rtl/uart_pkg.sv
// uart_pkg: shared UART transmitter types, line constants and baud helper.
// Contents:
//   state_t   - transmitter FSM encoding (PARITY only when UART_TX_PARITY_EN is defined)
//   START_BIT - line level of the start symbol
//   STOP_BIT  - line level of the stop symbol (also the idle level)
//   calc_cps  - clock cycles per serial symbol, truncating division
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        START  = 3'd2,
        DATA   = 3'd3,
`ifdef UART_TX_PARITY_EN
        PARITY = 3'd4,
`endif
        STOP   = 3'd5
    } state_t;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    function automatic int calc_cps(input int clock_freq, input int baud_rate);
        return clock_freq / baud_rate;
    endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// uart_baud_counter: free-running symbol timer that ticks on the last cycle of each symbol.
// Ports:
//   clk   - clock, rising edge
//   rst   - synchronous active-high reset, counter to 0
//   clear - synchronous restart of the symbol timer
//   tick  - high on cycle CPS-1 of the current symbol
module uart_baud_counter #(
    parameter int CPS = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);
    localparam int CW = (CPS > 1) ? $clog2(CPS) : 1;
    localparam logic [CW-1:0] LAST = CW'(CPS - 1);

    logic [CW-1:0] cnt;

    assign tick = cnt == LAST;

    always_ff @(posedge clk) begin
        if (rst || clear || tick)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: UART transmitter that pops words from an upstream FIFO and sends 8N1-style frames.
// Build option: define UART_TX_PARITY_EN to add an even-parity symbol between data and stop.
// Ports:
//   clk        - clock, rising edge
//   rst        - synchronous active-high reset; aborts any frame in flight
//   fifo_empty - upstream FIFO holds no data
//   fifo_dout  - upstream FIFO read data, valid the cycle after a pop
//   fifo_rd_en - one-cycle pop strobe, only in IDLE and only when the FIFO is non-empty
//   serial_out - registered UART line, idle high
//   busy       - high whenever the transmitter is not in IDLE
module fifo_uart_tx
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQ = 125_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int WIDTH      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_dout,
    output logic             fifo_rd_en,
    output logic             serial_out,
    output logic             busy
);
    localparam int CPS = calc_cps(CLOCK_FREQ, BAUD_RATE);
    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

    state_t           state, state_n;
    logic [WIDTH-1:0] shreg, shreg_n;
    logic [BW-1:0]    bit_cnt, bit_cnt_n;
    logic             tick;
    logic             line_n;
`ifdef UART_TX_PARITY_EN
    logic             par, par_n;
`endif

    // Every state change restarts the symbol timer so each symbol lasts exactly CPS cycles.
    uart_baud_counter #(.CPS(CPS)) u_baud (
        .clk   (clk),
        .rst   (rst),
        .clear (state_n != state),
        .tick  (tick)
    );

    assign busy = !rst && state != IDLE;

    always_comb begin
        state_n    = state;
        shreg_n    = shreg;
        bit_cnt_n  = bit_cnt;
        fifo_rd_en = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_n      = par;
`endif
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_rd_en = 1'b1;
                    state_n    = FETCH;
                end
            end
            FETCH: begin
                shreg_n   = fifo_dout;
                bit_cnt_n = '0;
`ifdef UART_TX_PARITY_EN
                par_n     = ^fifo_dout;
`endif
                state_n   = START;
            end
            START: state_n = tick ? DATA : START;
            DATA: begin
                if (tick) begin
                    shreg_n   = shreg >> 1;
                    bit_cnt_n = (bit_cnt == LAST_BIT) ? '0 : bit_cnt + 1'b1;
`ifdef UART_TX_PARITY_EN
                    state_n   = (bit_cnt == LAST_BIT) ? PARITY : DATA;
`else
                    state_n   = (bit_cnt == LAST_BIT) ? STOP : DATA;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: state_n = tick ? STOP : PARITY;
`endif
            STOP: state_n = tick ? IDLE : STOP;
            default: state_n = IDLE;
        endcase
        // Reset drops any popped word and blocks new pops.
        if (rst) begin
            state_n    = IDLE;
            fifo_rd_en = 1'b0;
        end
        // The line is registered from the level the next state will present.
`ifdef UART_TX_PARITY_EN
        line_n = (state_n == START)  ? START_BIT :
                 (state_n == DATA)   ? shreg_n[0] :
                 (state_n == PARITY) ? par_n : STOP_BIT;
`else
        line_n = (state_n == START) ? START_BIT :
                 (state_n == DATA)  ? shreg_n[0] : STOP_BIT;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            shreg      <= '0;
            bit_cnt    <= '0;
            serial_out <= STOP_BIT;
`ifdef UART_TX_PARITY_EN
            par        <= 1'b0;
`endif
        end else begin
            state      <= state_n;
            shreg      <= shreg_n;
            bit_cnt    <= bit_cnt_n;
            serial_out <= line_n;
`ifdef UART_TX_PARITY_EN
            par        <= par_n;
`endif
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: scoreboard bench for fifo_uart_tx with a queue-backed FIFO model and a line decoder.
module tb_fifo_uart_tx;
    localparam int CPS = 10;
`ifdef UART_TX_PARITY_EN
    localparam int NSYM = 11;
`else
    localparam int NSYM = 10;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       fifo_empty = 1'b1;
    logic [7:0] fifo_dout = 8'h00;
    logic       fifo_rd_en, serial_out, busy;

    fifo_uart_tx #(.CLOCK_FREQ(1000), .BAUD_RATE(100), .WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_empty (fifo_empty),
        .fifo_dout  (fifo_dout),
        .fifo_rd_en (fifo_rd_en),
        .serial_out (serial_out),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    logic [7:0] fq[$];
    logic [7:0] exp_q[$];
    int checks = 0, errors = 0;
    int pops = 0, pushed = 0, viol = 0, busy_cnt = 0, last_gap = 0;

    // Expected line symbols: start 0, data LSB first, optional even parity, stop 1.
    function automatic logic [NSYM-1:0] exp_wave(input logic [7:0] d);
        logic [NSYM-1:0] w;
        w = '1;
        w[0] = 1'b0;
        for (int i = 0; i < 8; i++) w[i+1] = d[i];
`ifdef UART_TX_PARITY_EN
        w[9] = ^d;
`endif
        return w;
    endfunction

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic send(input logic [7:0] d);
        fq.push_back(d);
        exp_q.push_back(d);
        pushed++;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || fq.size() != 0 || busy) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 5000) check("drain_timeout", n, 0);
    endtask

    // FIFO model: data and empty flag change just after the edge that samples the pop.
    initial begin : fifo_model
        logic pop;
        forever begin
            @(negedge clk);
            pop = fifo_rd_en;
            if (fifo_rd_en && (fifo_empty || rst)) viol++;
            if (fifo_rd_en) pops++;
            if (busy) busy_cnt++;
            @(posedge clk);
            #1;
            if (pop && fq.size() > 0) fifo_dout = fq.pop_front();
            fifo_empty = fq.size() == 0;
        end
    end

    // Line decoder: checks every symbol holds for CPS cycles and matches the next expected word.
    initial begin : monitor
        int mark;
        logic [NSYM-1:0] wave;
        logic [7:0] e;
        logic v, stable, aborted;
        mark = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                mark = 0;
                continue;
            end
            if (serial_out) begin
                mark++;
                continue;
            end
            last_gap = mark;
            mark = 0;
            stable = 1'b1;
            aborted = 1'b0;
            wave = '0;
            for (int s = 0; s < NSYM && !aborted; s++) begin
                v = serial_out;
                for (int c = 0; c < CPS; c++) begin
                    if (s != 0 || c != 0) @(negedge clk);
                    if (rst) begin
                        aborted = 1'b1;
                        break;
                    end
                    if (c == 0) v = serial_out;
                    else if (serial_out != v) stable = 1'b0;
                end
                wave[s] = v;
            end
            if (aborted) continue;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_frame: got %b expected none", wave);
            end else begin
                e = exp_q.pop_front();
                if (wave != exp_wave(e) || !stable) begin
                    errors++;
                    $display("FAIL frame_%02h: got %b stable %0d expected %b", e, wave, stable, exp_wave(e));
                end
            end
        end
    end

    initial begin : stim
        int bad, pops_at_rst, n;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_serial_out", int'(serial_out), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_rd_en", int'(fifo_rd_en), 0);
        @(posedge clk);
        #1 rst = 1'b0;

        bad = 0;
        repeat (500) begin
            @(negedge clk);
            if (fifo_rd_en || !serial_out || busy) bad++;
        end
        check("empty_idle_violations", bad, 0);

        busy_cnt = 0;
        send(8'hA5);
        drain();
        check("single_busy_cycles", busy_cnt, 1 + CPS * NSYM);
        check("single_pops", pops, 1);

        send(8'h00);
        send(8'hFF);
        drain();
        check("b2b_gap", last_gap, 2);

        send(8'h07);
        send(8'h03);
        drain();

        fq.push_back(8'h3C);
        pushed++;
        send(8'h5A);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (serial_out && n < 200);
        check("abort_start_seen", int'(serial_out), 0);
        repeat (35) @(posedge clk);
        #1 rst = 1'b1;
        pops_at_rst = pops;
        @(negedge clk);
        check("abort_rd_en_in_rst", int'(fifo_rd_en), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        check("abort_serial_out", int'(serial_out), 1);
        check("abort_busy", int'(busy), 0);
        check("abort_no_pop", pops, pops_at_rst);
        drain();

        for (int i = 0; i < 16; i++) begin
            send(8'($urandom));
            repeat ($urandom_range(0, 150)) @(posedge clk);
            #1;
        end
        drain();

        check("total_pops", pops, pushed);
        check("rd_en_violations", viol, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_uart_tx.md
FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 The block SHALL have parameter CLOCK_FREQ, default 125_000_000, meaning the clk frequency in Hz.
REQ-002 The block SHALL have parameter BAUD_RATE, default 115_200, meaning the serial bit rate in bits/s.
REQ-003 The block SHALL have parameter WIDTH, default 8, meaning the data bits per frame and the FIFO word width.
REQ-004 The block SHALL have port clk, input, 1 bit: clock, rising-edge active.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-006 The block SHALL have port fifo_empty, input, 1 bit: upstream FIFO holds no data.
REQ-007 The block SHALL have port fifo_dout, input, WIDTH bits: upstream FIFO read data, valid the cycle after a pop.
REQ-008 The block SHALL have port fifo_rd_en, output, 1 bit: one-cycle pop strobe to the upstream FIFO.
REQ-009 The block SHALL have port serial_out, output, 1 bit: UART line, idle high.
REQ-010 The block SHALL have port busy, output, 1 bit: high whenever the block is not in IDLE.

Function
REQ-011 The block SHALL compute CPS = CLOCK_FREQ / BAUD_RATE with integer truncation; each serial symbol lasts exactly CPS clk cycles.
REQ-012 The block SHALL use the states IDLE, FETCH, START, DATA, PARITY, STOP.
REQ-013 IDLE: when fifo_empty=0, the block SHALL assert fifo_rd_en for exactly one cycle and go to FETCH; otherwise it stays in IDLE with fifo_rd_en=0.
REQ-014 FETCH: the block SHALL wait one cycle, capture fifo_dout into the shift register at the end of that cycle, and go to START.
REQ-015 The block SHALL never assert fifo_rd_en outside IDLE, and it SHALL never assert fifo_rd_en while fifo_empty=1.
REQ-016 START: serial_out SHALL be 0 for CPS cycles.
REQ-017 DATA: the block SHALL send WIDTH bits LSB first, each for CPS cycles, using a bit counter of $clog2(WIDTH) bits that terminates at WIDTH-1.
REQ-018 STOP: serial_out SHALL be 1 for CPS cycles; the block SHALL then go to IDLE.
REQ-019 A new pop in IDLE SHALL be allowed on the cycle after STOP ends; the inter-frame mark gap is therefore 2 cycles (IDLE + FETCH) when the FIFO is non-empty.
REQ-020 serial_out SHALL be registered, with no combinational path from any input.
REQ-021 Changes on fifo_empty or fifo_dout after the capture SHALL NOT affect the frame in flight.
REQ-022 The baud counter SHALL reset to 0 on every state transition and SHALL wrap at CPS-1.

Reset
REQ-023 While rst=1, the block SHALL drive serial_out=1, fifo_rd_en=0 and busy=0, hold the state at IDLE, and set the baud counter, bit counter and shift register to 0.
REQ-024 If rst rises mid-frame, the block SHALL abort the frame, drive the line high on the next edge, and drop the popped byte without re-reading it.
REQ-025 After rst falls, the first pop SHALL occur no earlier than the first IDLE cycle.

Configuration
REQ-026 With UART_TX_PARITY_EN defined, the block SHALL insert a PARITY state between DATA and STOP that sends even parity (XOR of the data bits) for CPS cycles.
REQ-027 Without UART_TX_PARITY_EN, the block SHALL NOT build the PARITY state or its logic, and DATA SHALL go directly to STOP.

Structure
REQ-028 A shared package uart_pkg SHALL hold the state encoding typedef, the START_BIT=0 and STOP_BIT=1 constants, and a CPS helper function.
REQ-029 A single sub-module uart_baud_counter (parameter CPS; outputs a tick on the last cycle of each symbol; synchronous clear input) SHALL be instantiated once.

Verification (CLOCK_FREQ=1000, BAUD_RATE=100, so CPS=10)
REQ-030 Single byte: FIFO holds 0xA5 -> fifo_rd_en pulses once -> line sequence 0,1,0,1,0,0,1,0,1,1 with 10 cycles per bit -> frame lasts 100 cycles and busy falls after it.
REQ-031 Back-to-back: FIFO holds 0x00 then 0xFF -> two pops -> exactly 2 idle-high cycles between the end of the first STOP and the second START.
REQ-032 Empty FIFO: fifo_empty=1 held for 500 cycles -> fifo_rd_en=0, serial_out=1 and busy=0 throughout.
REQ-033 Reset mid-frame: rst pulsed for 1 cycle at cycle 35 of a 0x3C frame -> serial_out=1 on the next edge, state IDLE, and no extra pop during reset.
REQ-034 Parity build (UART_TX_PARITY_EN defined): byte 0x07 -> parity bit 1 -> frame lasts 110 cycles; byte 0x03 -> parity bit 0.
REQ-035 FIFO timing: the bench FIFO model updates fifo_dout one cycle after fifo_rd_en -> the captured byte equals the popped word for 16 random bytes.
